wb_cmd_master: RTL
==================

Name: wb_cmd_master

Overview:
Single-outstanding Wishbone classic initiator that turns a valid/ready command stream into one bus transaction per command. It returns a read data/error response on a valid/ready response stream. It sits between a sequencer or host-side command source and Wishbone responders such as the timer and other peripheral register blocks. A bounded ack timeout stops a missing or unmapped responder from hanging the bus.

Parameters:
TIMEOUT_CYCLES, 255, max cycles o_wb_stb is held without ack before abort (legal range 1..65535)
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of internal timeout counter (derived, not overridden)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  master can accept a command
i_cmd_adr  in  32  byte address
i_cmd_dat  in  32  write data
i_cmd_sel  in  4  byte selects
i_cmd_we  in  1  1 = write, 0 = read
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  response consumed
o_rsp_dat  out  32  read data (0 for writes and timeouts)
o_rsp_err  out  1  1 = transaction timed out
o_busy  out  1  high in any state other than IDLE
o_wb_adr  out  32  Wishbone address
o_wb_dat  out  32  Wishbone write data
o_wb_sel  out  4  Wishbone byte selects
o_wb_we  out  1  Wishbone write enable
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
i_wb_dat  in  32  Wishbone read data
i_wb_ack  in  1  Wishbone acknowledge

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs clear immediately, including o_wb_cyc/o_wb_stb and o_rsp_valid, even mid-transaction.
  - All state registers clear; state returns to IDLE.
  - Any in-flight transaction is dropped with no response.
- All outputs are registered. o_cmd_ready = (state == IDLE).
- States: IDLE, BUS, RESP.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid && o_cmd_ready at edge E0: latch adr/dat/sel/we onto o_wb_*, set o_wb_cyc = o_wb_stb = 1, clear counter, go to BUS.
  - o_wb_* hold their last values while idle. Only cyc/stb are meaningful to responders.
- BUS:
  - cyc, stb and the command fields are held stable until termination.
  - i_wb_ack is sampled only while o_wb_stb = 1.
  - Ack at an edge: on that same edge drop cyc/stb. Set o_rsp_dat = i_wb_dat for reads, or 0 for writes. Set o_rsp_err = 0, o_rsp_valid = 1, go to RESP.
  - No ack: counter increments. When the counter equals TIMEOUT_CYCLES-1 and no ack arrives on that edge, drop cyc/stb, set o_rsp_dat = 0, o_rsp_err = 1, o_rsp_valid = 1, go to RESP.
  - Ack and timeout on the same edge: ack wins.
  - Consequence: stb is high for at most TIMEOUT_CYCLES cycles.
- Latency against a zero-wait responder that asserts ack one cycle after stb:
  - cyc/stb high for 2 cycles.
  - o_rsp_valid rises 2 edges after the command handshake.
- RESP:
  - o_rsp_valid, o_rsp_dat and o_rsp_err are held stable until i_rsp_ready.
  - On o_rsp_valid && i_rsp_ready: clear o_rsp_valid, go to IDLE.
  - A new command is accepted no earlier than the next cycle; no bypass.
- Stray or late acks outside BUS (e.g. after a timeout) are ignored.
- No retry, no pipelined mode, no burst; exactly one outstanding transaction.
- The counter is CNT_W bits and cannot overflow because termination occurs at TIMEOUT_CYCLES-1.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE/BUS/RESP);
  - the default TIMEOUT_CYCLES constant;
  - the Wishbone width constants (ADR_W = 32, DAT_W = 32, SEL_W = 4), reused by responder blocks.
- No sub-module. FSM, counter and capture registers fit in one module.

Test Plan:
- Write against a timer-style responder: cmd adr 0x0, dat 0x0000_0010, sel 0xF, we 1 -> cyc/stb high 2 cycles; rsp_valid 2 edges after handshake; rsp_dat 0, err 0; responder prescaler reads back 0x10.
- Read back: cmd adr 0x0, we 0 -> o_rsp_dat = 0x0000_0010, err 0; exactly one ack observed per command.
- Timeout with TIMEOUT_CYCLES = 4 and ack tied low -> stb high exactly 4 cycles; then rsp_err = 1, rsp_dat = 0. A stray ack injected in RESP leaves the response unchanged.
- Response backpressure: hold i_rsp_ready = 0 for 5 cycles with i_cmd_valid = 1 -> o_cmd_ready = 0 and the response stays stable throughout. After ready, the next command is accepted one cycle later.
- Ack on the final timeout cycle (TIMEOUT_CYCLES = 4, ack on the 4th stb cycle) -> err = 0 and read data is captured.
- Reset asserted while stb is high -> cyc/stb/rsp_valid drop without a clock edge. After release: state IDLE, cmd_ready = 1, no response emitted.

Source files
------------

// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master and the
// peripheral responders that sit behind it.
package wb_cmd_master_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator: one bus transaction per
// command, read data / timeout error returned on a valid/ready response stream.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,

    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [ADR_W-1:0] i_cmd_adr,
    input  logic [DAT_W-1:0] i_cmd_dat,
    input  logic [SEL_W-1:0] i_cmd_sel,
    input  logic             i_cmd_we,

    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [DAT_W-1:0] o_rsp_dat,
    output logic             o_rsp_err,
    output logic             o_busy,

    output logic [ADR_W-1:0] o_wb_adr,
    output logic [DAT_W-1:0] o_wb_dat,
    output logic [SEL_W-1:0] o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    input  logic [DAT_W-1:0] i_wb_dat,
    input  logic             i_wb_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               we_q, we_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;

    // NOTE: every signal gets a hold-value default before the case so that no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    adr_d   = i_cmd_adr;
                    dat_d   = i_cmd_dat;
                    sel_d   = i_cmd_sel;
                    we_d    = i_cmd_we;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end

            ST_BUS: begin
                // Ack is checked before the timeout so it wins on the last cycle.
                if (stb_q && i_wb_ack) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : i_wb_dat;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_dat   = rsp_dat_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_we     = we_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;

endmodule
